// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the lab top level / bench (master) and the truth-table sequencer (slave).
// The master side also owns the table mux, so it supplies dut_y.
interface truth_table_sequencer_if #(
    parameter int MAX_IN = 4
);
    localparam int ROWS = 1 << MAX_IN;
    localparam int CW   = $clog2(ROWS + 1);

    logic              start;
    logic              abort;
    logic [2:0]        table_sel;
    logic [2:0]        n_in;
    logic [ROWS-1:0]   expected;
    logic              dut_y;
    logic [2:0]        dut_sel;
    logic [MAX_IN-1:0] dut_in;
    logic              busy;
    logic              row_valid;
    logic              done;
    logic              pass;
    logic              bad_cfg;
    logic [ROWS-1:0]   result;
    logic [MAX_IN-1:0] err_idx;
    logic [CW-1:0]     fail_cnt;

    modport master (
        output start, abort, table_sel, n_in, expected, dut_y,
        input  dut_sel, dut_in, busy, row_valid, done, pass, bad_cfg, result, err_idx, fail_cnt
    );

    modport slave (
        input  start, abort, table_sel, n_in, expected, dut_y,
        output dut_sel, dut_in, busy, row_valid, done, pass, bad_cfg, result, err_idx, fail_cnt
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all input rows of a selected combinational table, captures its output and
// compares the captured truth table against a golden vector.
//
// state  | meaning
// IDLE   | waiting for start, dut_in parked at 0
// SETTLE | current row driven, settle down-counter running
// SAMPLE | capture dut_y for current row, compare with golden bit
// FIN    | sweep complete, done pulse with pass verdict
// BADCFG | illegal n_in at start, done pulse with bad_cfg
module truth_table_sequencer #(
    parameter int MAX_IN = 4,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    truth_table_sequencer_if.slave bus
);
    localparam int ROWS = 1 << MAX_IN;
    localparam int CW   = $clog2(ROWS + 1);
    localparam logic [2:0]      N_MAX    = 3'(MAX_IN);
    localparam logic [3:0]      TMR_LOAD = 4'(SETTLE - 1);
    localparam logic [MAX_IN:0] ROW_ONE  = (MAX_IN+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FIN, S_BADCFG} state_t;

    state_t            state, state_nxt;
    logic [MAX_IN:0]   row, row_nxt;
    logic [3:0]        tmr, tmr_nxt;
    logic [2:0]        n_lat;
    logic [ROWS-1:0]   exp_lat;
    logic [ROWS-1:0]   result_nxt;
    logic [CW-1:0]     fail_nxt;
    logic [MAX_IN-1:0] err_nxt;
    logic              cfg_ok;
    logic              last_row;
    logic              go;

    assign cfg_ok   = (bus.n_in != 3'd0) && (bus.n_in <= N_MAX);
    assign last_row = (row == ((ROW_ONE << n_lat) - ROW_ONE));
    assign go       = (state == S_IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        tmr_nxt    = tmr;
        result_nxt = bus.result;
        fail_nxt   = bus.fail_cnt;
        err_nxt    = bus.err_idx;
        case (state)
            S_IDLE: begin
                if (go && cfg_ok) begin
                    state_nxt  = S_SETTLE;
                    row_nxt    = '0;
                    tmr_nxt    = TMR_LOAD;
                    result_nxt = '0;
                    fail_nxt   = '0;
                    err_nxt    = '0;
                end else if (go) begin
                    state_nxt  = S_BADCFG;
                    result_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (bus.abort)         state_nxt = S_IDLE;
                else if (tmr == 4'd0)  state_nxt = S_SAMPLE;
                else                   tmr_nxt   = tmr - 4'd1;
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    result_nxt[row[MAX_IN-1:0]] = bus.dut_y;
                    if (bus.dut_y != exp_lat[row[MAX_IN-1:0]]) begin
                        if (bus.fail_cnt != CW'(ROWS)) fail_nxt = bus.fail_cnt + CW'(1);
                        if (bus.fail_cnt == '0)        err_nxt  = row[MAX_IN-1:0];
                    end
                    if (last_row) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt = S_SETTLE;
                        row_nxt   = row + ROW_ONE;
                        tmr_nxt   = TMR_LOAD;
                    end
                end
            end
            S_FIN, S_BADCFG: state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row           <= '0;
            tmr           <= '0;
            n_lat         <= '0;
            exp_lat       <= '0;
            bus.dut_sel   <= '0;
            bus.dut_in    <= '0;
            bus.busy      <= 1'b0;
            bus.row_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.bad_cfg   <= 1'b0;
            bus.result    <= '0;
            bus.err_idx   <= '0;
            bus.fail_cnt  <= '0;
        end else begin
            row          <= row_nxt;
            tmr          <= tmr_nxt;
            bus.result   <= result_nxt;
            bus.fail_cnt <= fail_nxt;
            bus.err_idx  <= err_nxt;
            if (go && cfg_ok) begin
                bus.dut_sel <= bus.table_sel;
                n_lat       <= bus.n_in;
                exp_lat     <= bus.expected;
            end
            bus.busy      <= (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
            bus.row_valid <= (state_nxt == S_SAMPLE);
            bus.done      <= (state_nxt == S_FIN) || (state_nxt == S_BADCFG);
            bus.dut_in    <= ((state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE)) ?
                             row_nxt[MAX_IN-1:0] : '0;
            if (state_nxt == S_FIN)         bus.pass <= (fail_nxt == '0);
            else if (state_nxt != S_IDLE)   bus.pass <= 1'b0;
            if (state_nxt == S_BADCFG)                             bus.bad_cfg <= 1'b1;
            else if (state == S_IDLE && state_nxt == S_SETTLE)     bus.bad_cfg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: XOR3 / AND4 tables, golden mismatches,
// abort, bad configuration, start-while-busy and mid-sweep reset.
module tb_truth_table_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    truth_table_sequencer_if #(.MAX_IN(4)) bus ();

    truth_table_sequencer #(.MAX_IN(4), .SETTLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Table mux: 0 = XOR of A B C, 1 = AND of A B C D.
    always_comb begin
        case (bus.dut_sel)
            3'd0:    bus.dut_y = ^bus.dut_in[2:0];
            3'd1:    bus.dut_y = &bus.dut_in;
            default: bus.dut_y = 1'b0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point of cycle 1 (the start edge is edge 0).
    task automatic start_req(input logic [2:0] sel, input logic [2:0] n, input logic [15:0] exp);
        bus.table_sel = sel;
        bus.n_in      = n;
        bus.expected  = exp;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Follows a sweep (SETTLE=1) from cycle 1 until done; checks each cycle against the row schedule.
    task automatic watch(input logic [2:0] sel, input int n, input int poke,
                         output int done_cyc, output int rv, output int seq_err);
        int rows;
        int exp_row;
        rows     = 1 << n;
        done_cyc = -1;
        rv       = 0;
        seq_err  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            exp_row = (c - 1) / 2;
            if (c <= 2 * rows) begin
                if (bus.dut_in !== 4'(exp_row))            seq_err++;
                if (bus.row_valid !== ((c % 2) == 0))      seq_err++;
                if (bus.busy !== 1'b1)                     seq_err++;
                if (bus.dut_sel !== sel)                   seq_err++;
            end else begin
                seq_err++;
            end
            if (bus.row_valid === 1'b1) rv++;
            bus.start = (c == poke);
            if (c == poke) begin
                bus.table_sel = 3'd1;
                bus.n_in      = 3'd1;
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    int dc, rv, se, nd;

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.table_sel = 3'd0;
        bus.n_in      = 3'd0;
        bus.expected  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({bus.dut_sel, bus.dut_in, bus.busy, bus.row_valid, bus.done,
                               bus.pass, bus.bad_cfg}), 32'h0);
        chk("reset_data", 32'({bus.result, bus.err_idx, bus.fail_cnt}), 32'h0);
        rst_n = 1'b1;
        tick();

        // XOR3 against matching golden
        start_req(3'd0, 3'd3, 16'h0096);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("xor_done_cyc", 32'(dc), 32'd17);
        chk("xor_row_valids", 32'(rv), 32'd8);
        chk("xor_schedule", 32'(se), 32'd0);
        chk("xor_pass", 32'(bus.pass), 32'd1);
        chk("xor_result", 32'(bus.result), 32'h0096);
        chk("xor_fail_err", 32'({bus.fail_cnt, bus.err_idx}), 32'h0);
        chk("xor_fin_idle", 32'({bus.busy, bus.dut_in}), 32'h0);
        tick();
        chk("xor_done_pulse", 32'(bus.done), 32'd0);
        chk("xor_pass_hold", 32'(bus.pass), 32'd1);

        // Row 0 golden flipped
        start_req(3'd0, 3'd3, 16'h0097);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("g97_done_cyc", 32'(dc), 32'd17);
        chk("g97_pass", 32'(bus.pass), 32'd0);
        chk("g97_fail_cnt", 32'(bus.fail_cnt), 32'd1);
        chk("g97_err_idx", 32'(bus.err_idx), 32'd0);
        chk("g97_result", 32'(bus.result), 32'h0096);
        tick();

        // Row 4 flipped, upper golden bits must be ignored
        start_req(3'd0, 3'd3, 16'hFF86);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("gff86_fail_cnt", 32'(bus.fail_cnt), 32'd1);
        chk("gff86_err_idx", 32'(bus.err_idx), 32'd4);
        chk("gff86_result", 32'(bus.result), 32'h0096);
        tick();

        // Every row wrong: first failure stays row 0
        start_req(3'd0, 3'd3, 16'h0069);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("g69_fail_cnt", 32'(bus.fail_cnt), 32'd8);
        chk("g69_err_idx", 32'(bus.err_idx), 32'd0);
        chk("g69_pass", 32'(bus.pass), 32'd0);
        tick();

        // AND4, full MAX_IN sweep
        start_req(3'd1, 3'd4, 16'h8000);
        watch(3'd1, 4, 0, dc, rv, se);
        chk("and_done_cyc", 32'(dc), 32'd33);
        chk("and_row_valids", 32'(rv), 32'd16);
        chk("and_schedule", 32'(se), 32'd0);
        chk("and_pass", 32'(bus.pass), 32'd1);
        chk("and_result", 32'(bus.result), 32'h8000);
        tick();

        // Abort in row 3 SETTLE (cycle 7)
        start_req(3'd0, 3'd3, 16'h0096);
        repeat (6) tick();
        chk("abort_pre_row", 32'({bus.busy, bus.dut_in}), 32'h13);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", 32'({bus.busy, bus.dut_in}), 32'h0);
        chk("abort_partial", 32'(bus.result), 32'h0006);
        chk("abort_pass", 32'(bus.pass), 32'd0);
        nd = int'(bus.done);
        repeat (20) begin
            tick();
            nd += int'(bus.done);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        start_req(3'd0, 3'd3, 16'h0096);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("post_abort_done", 32'(dc), 32'd17);
        chk("post_abort_pass", 32'(bus.pass), 32'd1);
        tick();

        // start together with abort in IDLE
        bus.n_in  = 3'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("start_abort_quiet", 32'({bus.busy, bus.done}), 32'h0);

        // Illegal n_in
        start_req(3'd2, 3'd0, 16'hFFFF);
        chk("bad0_flags", 32'({bus.done, bus.bad_cfg, bus.pass, bus.busy}), 32'b1100);
        chk("bad0_result", 32'(bus.result), 32'h0);
        tick();
        chk("bad0_after", 32'({bus.done, bus.busy, bus.bad_cfg}), 32'b001);
        start_req(3'd2, 3'd5, 16'hFFFF);
        chk("bad5_flags", 32'({bus.done, bus.bad_cfg, bus.busy}), 32'b110);
        tick();

        // start while busy is ignored
        start_req(3'd0, 3'd3, 16'h0096);
        watch(3'd0, 3, 5, dc, rv, se);
        chk("busy_start_done", 32'(dc), 32'd17);
        chk("busy_start_sched", 32'(se), 32'd0);
        chk("busy_start_pass", 32'({bus.pass, bus.bad_cfg}), 32'b10);
        tick();

        // Asynchronous reset mid-sweep (row 5, cycle 11)
        start_req(3'd0, 3'd3, 16'h0096);
        repeat (10) tick();
        chk("rst_pre_state", 32'({bus.busy, bus.dut_in, bus.result}), 32'h1_5_0016);
        rst_n = 1'b0;
        #2;
        chk("rst_async_ctl", 32'({bus.dut_sel, bus.dut_in, bus.busy, bus.row_valid, bus.done,
                                   bus.pass, bus.bad_cfg}), 32'h0);
        chk("rst_async_data", 32'({bus.result, bus.err_idx, bus.fail_cnt}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_req(3'd0, 3'd3, 16'h0096);
        watch(3'd0, 3, 0, dc, rv, se);
        chk("post_rst_done", 32'(dc), 32'd17);
        chk("post_rst_pass", 32'(bus.pass), 32'd1);
        chk("post_rst_result", 32'(bus.result), 32'h0096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
